// File: rtl/pipe_pkg.sv
// Shared types and constants for every pipe_stage_reg instance in the pipeline.
// Holds the stage state encoding, occupancy codes and control-bundle field offsets.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Control bundle layout shared by IF/ID, ID/EX, EX/MEM and MEM/WB instances.
    localparam int CTRL_WBSEL_LSB  = 0;
    localparam int CTRL_WBSEL_W    = 2;
    localparam int CTRL_REGWEN_BIT = 2;
    localparam int CTRL_MEMR_BIT   = 3;
    localparam int CTRL_MEMW_BIT   = 4;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one bundle register with a valid bit.
// clear drops the valid bit but keeps the payload; clear wins over load.
module pipe_slot #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with stall and flush (bubble insertion).
// Define PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
//   state | meaning
//   EMPTY | nothing held, out_valid=0
//   ONE   | main slot holds the beat on out_*
//   FULL  | main and skid slots both hold beats, in_ready=0 (PIPE_SKID_EN only)
import pipe_pkg::*;

module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occ
);

    localparam int W = DATA_W + CTRL_W;

    pipe_state_e  state, state_nxt;
    logic         in_fire, out_fire;
    logic         main_load, main_clear, main_valid;
    logic [W-1:0] main_d, main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic         skid_load, skid_clear, skid_valid, main_from_skid;
    logic [W-1:0] skid_q;

    pipe_slot #(.W(W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     ({in_data, in_ctrl}),
        .q     (skid_q),
        .valid (skid_valid)
    );

    assign main_d = main_from_skid ? skid_q : {in_data, in_ctrl};
    assign occ    = skid_valid ? OCC_FULL : (main_valid ? OCC_ONE : OCC_EMPTY);

    // Ready comes from a flop so the downstream ready never reaches upstream in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready <= 1'b1;
        else     in_ready <= (state_nxt != FULL);
    end
`else
    assign main_d   = {in_data, in_ctrl};
    assign occ      = main_valid ? OCC_ONE : OCC_EMPTY;
    assign in_ready = ~main_valid | out_ready;
`endif

    pipe_slot #(.W(W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (main_q),
        .valid (main_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
`ifdef PIPE_SKID_EN
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
`endif
        if (flush) begin
            state_nxt  = EMPTY;
            main_clear = 1'b1;
`ifdef PIPE_SKID_EN
            skid_clear = 1'b1;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
`ifdef PIPE_SKID_EN
                    if (in_fire && !out_fire) begin
                        state_nxt = FULL;
                        skid_load = 1'b1;
                    end else
`endif
                    if (in_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_nxt  = EMPTY;
                        main_clear = 1'b1;
                    end
                end
`ifdef PIPE_SKID_EN
                FULL: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
`endif
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Control is masked while invalid so a stale bundle can never act as a real instruction.
    assign out_valid = main_valid;
    assign out_data  = main_q[W-1:CTRL_W];
    assign out_ctrl  = main_valid ? main_q[CTRL_W-1:0] : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours PIPE_SKID_EN like the RTL.
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int CW = 8;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occ;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;
    typedef logic [DW-1:0] dq_t[$];

    int            n_cmp = 0, n_fail = 0, cyc = 0;
    beat_t         mq[$];
    logic [DW-1:0] m_last = '0;
    beat_t         drv_q[$];
    logic [CW-1:0] idle_ctrl = '0;
    logic [DW-1:0] dlog[$];
    int            dstamp[$];
    bit            pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of held beats bounded by CAP; the head is what the stage shows.
    function automatic bit m_ready();
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit inf, outf;
        beat_t b;
        if (rst) begin
            mq.delete();
            m_last = '0;
        end else begin
            outf = (mq.size() > 0) && out_ready;
            inf  = in_valid && m_ready();
            if (flush) begin
                mq.delete();
            end else begin
                if (outf) void'(mq.pop_front());
                if (inf) begin
                    b.d = in_data;
                    b.c = in_ctrl;
                    mq.push_back(b);
                end
            end
            if (mq.size() > 0) m_last = mq[0].d;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", out_valid, mq.size() > 0);
            chk("in_ready", in_ready, m_ready());
            chk("occ", occ, mq.size());
            chk("out_data", out_data, (mq.size() > 0) ? mq[0].d : m_last);
            chk("out_ctrl", out_ctrl, (mq.size() > 0) ? mq[0].c : 8'h00);
            if (out_valid && out_ready) begin
                dlog.push_back(out_data);
                dstamp.push_back(cyc);
            end
        end
    end

    // Presents drv_q head, holding it until the handshake completes.
    initial forever begin
        @(negedge clk);
        pend = in_valid && in_ready && !flush;
        @(posedge clk);
        #1;
        if (pend && drv_q.size() > 0) void'(drv_q.pop_front());
        if (drv_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = drv_q[0].d;
            in_ctrl  = drv_q[0].c;
        end else begin
            in_valid = 1'b0;
            in_ctrl  = idle_ctrl;
        end
    end

    task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c);
        beat_t b;
        b.d = d;
        b.c = c;
        drv_q.push_back(b);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((drv_q.size() > 0 || in_valid || out_valid) && k < 300) begin
            step(1);
            k++;
        end
        chk({name, "_drain_in_time"}, k < 300, 1'b1);
    endtask

    task automatic check_log(input string name, input dq_t exp);
        chk({name, "_count"}, dlog.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(name, (i < dlog.size()) ? 64'(dlog[i]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp[i]));
    endtask

    initial begin
        dq_t exp;
        logic [23:0] pat;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_occ", occ, 2'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_ctrl", out_ctrl, 8'h00);

        // Streaming: 0x100..0x10F back to back.
        step(1);
        out_ready = 1'b1;
        dlog.delete();
        dstamp.delete();
        exp.delete();
        for (int i = 0; i < 16; i++) begin
            push(32'h100 + i, 8'(i + 1));
            exp.push_back(32'h100 + i);
        end
        drain("stream");
        check_log("stream", exp);
        chk("stream_no_gaps", (dstamp.size() == 16) ? dstamp[15] - dstamp[0] : -1, 15);

        // Backpressure.
        dlog.delete();
        out_ready = 1'b0;
        push(32'hA, 8'h11);
        push(32'hB, 8'h12);
        push(32'hC, 8'h13);
        step(4);
        @(negedge clk);
        chk("bp_occ", occ, 2'(CAP));
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_data", out_data, 32'hA);
        chk("bp_out_ctrl", out_ctrl, 8'h11);
        chk("bp_pending", drv_q.size(), 3 - CAP);
        step(1);
        out_ready = 1'b1;
        drain("bp");
        exp = '{32'hA, 32'hB, 32'hC};
        check_log("bp", exp);

        // Flush with the stage full and 0xD presented.
        dlog.delete();
        out_ready = 1'b0;
        push(32'h1E, 8'h21);
        push(32'h1F, 8'h22);
        push(32'hD, 8'h23);
        step(3);
        flush = 1'b1;
        drv_q.delete();
        step(1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_occ", occ, 2'd0);
        chk("flush_out_ctrl", out_ctrl, 8'h00);
        chk("flush_out_data_kept", out_data, 32'h1E);
        step(1);
        out_ready = 1'b1;
        step(4);
        chk("flush_nothing_out", dlog.size(), 0);

        // Flush drops a beat even when in_valid && in_ready.
        push(32'h77, 8'h44);
        step(1);
        flush = 1'b1;
        drv_q.delete();
        step(1);
        flush = 1'b0;
        step(3);
        chk("flush_accept_dropped", dlog.size(), 0);
        chk("flush_accept_out_valid", out_valid, 1'b0);

        // Bubble safety.
        idle_ctrl = 8'hFF;
        step(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bubble_ctrl", out_ctrl, 8'h00);
        end
        idle_ctrl = 8'h00;

        // Mixed backpressure pattern.
        step(1);
        dlog.delete();
        exp.delete();
        pat = 24'b1011_0011_1001_0110_0101_1100;
        for (int i = 0; i < 12; i++) begin
            push(32'h200 + i, 8'(8'h80 | i));
            exp.push_back(32'h200 + i);
        end
        for (int k = 0; k < 24; k++) begin
            out_ready = pat[k];
            step(1);
        end
        out_ready = 1'b1;
        drain("mixed");
        check_log("mixed", exp);

        // Asynchronous reset mid-stall.
        out_ready = 1'b0;
        push(32'h300, 8'h31);
        push(32'h301, 8'h32);
        push(32'h302, 8'h33);
        step(4);
        @(negedge clk);
        chk("prerst_occ", occ, 2'(CAP));
        #1 rst = 1'b1;
        drv_q.delete();
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_ctrl", out_ctrl, 8'h00);
        chk("arst_occ", occ, 2'd0);
        chk("arst_in_ready", in_ready, 1'b1);
        step(1);
        rst = 1'b0;
        dlog.delete();
        out_ready = 1'b1;
        push(32'h400, 8'h41);
        push(32'h401, 8'h42);
        drain("post_rst");
        exp = '{32'h400, 32'h401};
        check_log("post_rst", exp);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
